// File: rtl/msg_scroll_display.sv
// Buffered ASCII message scroller driving NUM_DIGITS active-low 7-segment digits.
// Define MSG_SCROLL_GAP_EN to insert NUM_DIGITS blank positions between repeats.
module msg_scroll_display #(
    parameter int NUM_DIGITS = 6,
    parameter int DEPTH      = 16,
    parameter int TICK_DIV   = 25000000
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          wr_valid,
    output logic                          wr_ready,
    input  logic [7:0]                    wr_data,
    input  logic                          wr_last,
    input  logic                          clear,
    output logic                          busy,
    output logic [$clog2(DEPTH+1)-1:0]    msg_len,
    output logic [7*NUM_DIGITS-1:0]       seg_out
);

    localparam int LW = $clog2(DEPTH + 1);
    localparam int MW = $clog2(DEPTH);
    localparam int PW = $clog2(DEPTH + NUM_DIGITS + 1);
    localparam int TW = $clog2(TICK_DIV);

    typedef enum logic [1:0] {IDLE, LOAD, SCROLL} state_t;

    state_t                  state, state_nx;
    logic [7:0]              mem [DEPTH];
    logic [PW-1:0]           pos;
    logic [PW-1:0]           loop_len;
    logic [PW-1:0]           idx;
    logic [TW-1:0]           tick;
    logic                    xfer;
    logic                    tick_end;
    logic [7*NUM_DIGITS-1:0] frame;

    function automatic logic [6:0] decode(input logic [7:0] c);
        logic [7:0] uc;
        uc = (c >= 8'h61 && c <= 8'h7a) ? c - 8'd32 : c;
        case (uc)
            8'h30:   decode = 7'b1000000;
            8'h31:   decode = 7'b1111001;
            8'h32:   decode = 7'b0100100;
            8'h33:   decode = 7'b0110000;
            8'h34:   decode = 7'b0011001;
            8'h35:   decode = 7'b0010010;
            8'h36:   decode = 7'b0000010;
            8'h37:   decode = 7'b1111000;
            8'h38:   decode = 7'b0000000;
            8'h39:   decode = 7'b0010000;
            8'h41:   decode = 7'b0001000;
            8'h42:   decode = 7'b0000011;
            8'h43:   decode = 7'b1000110;
            8'h44:   decode = 7'b0100001;
            8'h45:   decode = 7'b0000110;
            8'h46:   decode = 7'b0001110;
            8'h48:   decode = 7'b0001001;
            8'h4c:   decode = 7'b1000111;
            8'h4f:   decode = 7'b1000000;
            8'h50:   decode = 7'b0001100;
            8'h55:   decode = 7'b1000001;
            default: decode = 7'b1111111;
        endcase
    endfunction

    assign wr_ready = (state == IDLE) ||
                      (state == LOAD && msg_len < LW'(DEPTH));
    assign busy     = (state == SCROLL);
    assign xfer     = wr_valid && wr_ready && !clear;
    assign tick_end = (tick == TW'(TICK_DIV - 1));

`ifdef MSG_SCROLL_GAP_EN
    assign loop_len = PW'(msg_len) + PW'(NUM_DIGITS);
`else
    assign loop_len = PW'(msg_len);
`endif

    always_comb begin
        state_nx = state;
        if (clear) begin
            state_nx = IDLE;
        end else if (xfer) begin
            if (wr_last || msg_len == LW'(DEPTH - 1))
                state_nx = SCROLL;
            else
                state_nx = LOAD;
        end
    end

    // Walk the window left to right, wrapping the index at the loop length.
    always_comb begin
        frame = '1;
        idx   = pos;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (idx < PW'(msg_len))
                frame[7*(NUM_DIGITS-1-k) +: 7] = decode(mem[idx[MW-1:0]]);
            idx = (idx + PW'(1) == loop_len) ? '0 : idx + PW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset)
            state <= IDLE;
        else
            state <= state_nx;
    end

    always_ff @(posedge clk) begin
        if (xfer)
            mem[msg_len[MW-1:0]] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (reset || clear) begin
            msg_len <= '0;
            pos     <= '0;
            tick    <= '0;
            seg_out <= '1;
        end else begin
            if (xfer)
                msg_len <= msg_len + LW'(1);
            if (state == SCROLL) begin
                seg_out <= frame;
                if (tick_end) begin
                    tick <= '0;
                    pos  <= (pos + PW'(1) == loop_len) ? '0 : pos + PW'(1);
                end else begin
                    tick <= tick + TW'(1);
                end
            end else begin
                seg_out <= '1;
            end
        end
    end

endmodule
